// File: rtl/cond_exec_unit_pkg.sv
// Shared constants for the condition execution unit: ARM condition codes and NZCV bit positions.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FN = 3;
  localparam int FZ = 2;
  localparam int FC = 1;
  localparam int FV = 0;

endpackage

// File: rtl/cond_exec_unit_if.sv
// Pipeline-side bundle of the condition execution unit: flag write, lane conditions, IT control and results.
interface cond_exec_unit_if #(
  parameter int NUM_LANES = 1
);
  logic                   flag_we;
  logic [3:0]             flag_in;
  logic [NUM_LANES-1:0]   cond_valid;
  logic [4*NUM_LANES-1:0] cond;
  logic                   stall;
  logic                   flush;
  logic                   it_load;
  logic [3:0]             it_cond;
  logic [3:0]             it_mask;
  logic [2:0]             it_len;
  logic [NUM_LANES-1:0]   pass;
  logic [NUM_LANES-1:0]   pass_valid;
  logic [3:0]             sr_flags;
  logic                   it_busy;

  modport master (
    output flag_we, flag_in, cond_valid, cond, stall, flush, it_load, it_cond, it_mask, it_len,
    input  pass, pass_valid, sr_flags, it_busy
  );

  modport slave (
    input  flag_we, flag_in, cond_valid, cond, stall, flush, it_load, it_cond, it_mask, it_len,
    output pass, pass_valid, sr_flags, it_busy
  );
endinterface

// File: rtl/cond_exec_unit_cond_eval.sv
// Combinational ARM condition-field evaluator against an NZCV flag vector.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       hit_o
);

  logic n_s, z_s, c_s, v_s;
  assign n_s = flags_i[FN];
  assign z_s = flags_i[FZ];
  assign c_s = flags_i[FC];
  assign v_s = flags_i[FV];

  // condition decode
  always_comb begin
    hit_o = 1'b0;
    case (cond_i)
      COND_EQ: hit_o = z_s;
      COND_NE: hit_o = ~z_s;
      COND_CS: hit_o = c_s;
      COND_CC: hit_o = ~c_s;
      COND_MI: hit_o = n_s;
      COND_PL: hit_o = ~n_s;
      COND_VS: hit_o = v_s;
      COND_VC: hit_o = ~v_s;
      COND_HI: hit_o = c_s & ~z_s;
      COND_LS: hit_o = ~c_s | z_s;
      COND_GE: hit_o = (n_s == v_s);
      COND_LT: hit_o = (n_s != v_s);
      COND_GT: hit_o = ~z_s & (n_s == v_s);
      COND_LE: hit_o = z_s | (n_s != v_s);
      COND_AL: hit_o = 1'b1;
      COND_NV: hit_o = 1'b0;
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_unit.sv
// NZCV status register, per-lane condition evaluation and IT-style predicate block on lane 0,
// with an optional registered result stage.
module cond_exec_unit
  import cond_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int BYPASS    = 1,
  parameter int REG_OUT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  cond_exec_unit_if.slave   bus
);

  logic [3:0]           sr_q, sr_d;
  logic [3:0]           eff_flags_s;
  logic [2:0]           it_cnt_q, it_cnt_d;
  logic [1:0]           it_idx_q, it_idx_d;
  logic [3:0]           it_cond_q, it_cond_d;
  logic [3:0]           it_mask_q, it_mask_d;
  logic                 it_busy_s;
  logic                 consume_s;
  logic [3:0]           lane0_cond_s;
  logic [NUM_LANES-1:0] hit_s;
  logic [NUM_LANES-1:0] p_s;
  logic [NUM_LANES-1:0] pv_s;

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q      <= 4'h0;
      it_cnt_q  <= 3'd0;
      it_idx_q  <= 2'd0;
      it_cond_q <= 4'h0;
      it_mask_q <= 4'h0;
    end else begin
      sr_q      <= sr_d;
      it_cnt_q  <= it_cnt_d;
      it_idx_q  <= it_idx_d;
      it_cond_q <= it_cond_d;
      it_mask_q <= it_mask_d;
    end
  end

  // SR writes ignore stall/flush: the flag producer is older than anything being killed
  always_comb begin
    sr_d = sr_q;
    if (bus.flag_we) begin
      sr_d = bus.flag_in;
    end else begin
      sr_d = sr_q;
    end
  end

  assign eff_flags_s = ((BYPASS != 0) && bus.flag_we) ? bus.flag_in : sr_q;
  assign it_busy_s   = (it_cnt_q != 3'd0);
  assign consume_s   = bus.cond_valid[0] & ~bus.stall & it_busy_s;

  // IT block sequencing: flush beats load, load beats consume
  always_comb begin
    it_cnt_d  = it_cnt_q;
    it_idx_d  = it_idx_q;
    it_cond_d = it_cond_q;
    it_mask_d = it_mask_q;
    if (bus.flush) begin
      it_cnt_d = 3'd0;
    end else if (bus.it_load && (bus.it_len != 3'd0)) begin
      it_cnt_d  = bus.it_len;
      it_idx_d  = 2'd0;
      it_cond_d = bus.it_cond;
      it_mask_d = bus.it_mask;
    end else if (consume_s) begin
      it_cnt_d = it_cnt_q - 3'd1;
      it_idx_d = it_idx_q + 2'd1;
    end else begin
      it_cnt_d = it_cnt_q;
    end
  end

  // lane 0 condition override while a predicate block is active
  always_comb begin
    lane0_cond_s = bus.cond[3:0];
    if (it_busy_s) begin
      if (it_mask_q[it_idx_q]) begin
        lane0_cond_s = it_cond_q;
      end else begin
        lane0_cond_s = it_cond_q ^ 4'b0001;
      end
    end else begin
      lane0_cond_s = bus.cond[3:0];
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [3:0] lane_cond_s;
    if (i == 0) begin : g_l0
      assign lane_cond_s = lane0_cond_s;
    end else begin : g_ln
      assign lane_cond_s = bus.cond[4*i +: 4];
    end
    cond_eval u_eval (
      .cond_i  (lane_cond_s),
      .flags_i (eff_flags_s),
      .hit_o   (hit_s[i])
    );
  end

  // per-lane results; lanes above 0 are squashed during a predicate block
  always_comb begin
    p_s  = '0;
    pv_s = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if ((i == 0) || !it_busy_s) begin
        pv_s[i] = bus.cond_valid[i];
        p_s[i]  = bus.cond_valid[i] & hit_s[i];
      end else begin
        pv_s[i] = 1'b0;
        p_s[i]  = 1'b0;
      end
    end
  end

  if (REG_OUT != 0) begin : g_reg
    logic [NUM_LANES-1:0] pass_q;
    logic [NUM_LANES-1:0] pv_q;

    // output stage: flush wins over stall
    always_ff @(posedge clk) begin
      if (rst) begin
        pass_q <= '0;
        pv_q   <= '0;
      end else if (bus.flush) begin
        pass_q <= '0;
        pv_q   <= '0;
      end else if (!bus.stall) begin
        pass_q <= p_s;
        pv_q   <= pv_s;
      end else begin
        pass_q <= pass_q;
        pv_q   <= pv_q;
      end
    end

    assign bus.pass       = pass_q;
    assign bus.pass_valid = pv_q;
  end else begin : g_comb
    assign bus.pass       = p_s;
    assign bus.pass_valid = pv_s;
  end

  assign bus.sr_flags = sr_q;
  assign bus.it_busy  = it_busy_s;

endmodule

// File: tb/tb_cond_exec_unit.sv
// Directed bench: dut_a (bypass, registered) and dut_b (no bypass, combinational), both two lanes, shared stimulus.
module tb_cond_exec_unit;

  logic       clk;
  logic       rst;
  logic       flag_we;
  logic [3:0] flag_in;
  logic [1:0] cond_valid;
  logic [7:0] cond;
  logic       stall;
  logic       flush;
  logic       it_load;
  logic [3:0] it_cond;
  logic [3:0] it_mask;
  logic [2:0] it_len;

  int n_checks;
  int n_fail;

  cond_exec_unit_if #(.NUM_LANES(2)) ifa ();
  cond_exec_unit_if #(.NUM_LANES(2)) ifb ();

  assign ifa.flag_we = flag_we;    assign ifb.flag_we = flag_we;
  assign ifa.flag_in = flag_in;    assign ifb.flag_in = flag_in;
  assign ifa.cond_valid = cond_valid; assign ifb.cond_valid = cond_valid;
  assign ifa.cond = cond;          assign ifb.cond = cond;
  assign ifa.stall = stall;        assign ifb.stall = stall;
  assign ifa.flush = flush;        assign ifb.flush = flush;
  assign ifa.it_load = it_load;    assign ifb.it_load = it_load;
  assign ifa.it_cond = it_cond;    assign ifb.it_cond = it_cond;
  assign ifa.it_mask = it_mask;    assign ifb.it_mask = it_mask;
  assign ifa.it_len = it_len;      assign ifb.it_len = it_len;

  cond_exec_unit #(.NUM_LANES(2), .BYPASS(1), .REG_OUT(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  cond_exec_unit #(.NUM_LANES(2), .BYPASS(0), .REG_OUT(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic b;
    case (c[3:1])
      3'd0:    b = f[2];
      3'd1:    b = f[1];
      3'd2:    b = f[3];
      3'd3:    b = f[0];
      3'd4:    b = f[1] & ~f[2];
      3'd5:    b = (f[3] == f[0]);
      3'd6:    b = ~f[2] & (f[3] == f[0]);
      default: b = 1'b1;
    endcase
    return c[0] ? ~b : b;
  endfunction

  initial begin
    logic m;
    n_checks = 0; n_fail = 0;
    rst = 1'b1; flag_we = 1'b0; flag_in = 4'h0; cond_valid = 2'b00; cond = 8'h00;
    stall = 1'b0; flush = 1'b0; it_load = 1'b0; it_cond = 4'h0; it_mask = 4'h0; it_len = 3'd0;
    tick(); tick();
    check_eq("rst_pass_a", {6'd0, ifa.pass}, 8'h00);
    check_eq("rst_pv_a", {6'd0, ifa.pass_valid}, 8'h00);
    check_eq("rst_sr_a", {4'd0, ifa.sr_flags}, 8'h00);
    check_eq("rst_busy_a", {7'd0, ifa.it_busy}, 8'h00);
    check_eq("rst_sr_b", {4'd0, ifb.sr_flags}, 8'h00);
    rst = 1'b0;

    // T1: write Z, then EQ / NE
    flag_we = 1'b1; flag_in = 4'b0100;
    tick();
    flag_we = 1'b0; cond = 8'h00; cond_valid = 2'b01;
    #1;
    check_eq("t1_eq_b", {6'd0, ifb.pass}, 8'h01);
    tick();
    check_eq("t1_eq_a", {6'd0, ifa.pass}, 8'h01);
    check_eq("t1_pv_a", {6'd0, ifa.pass_valid}, 8'h01);
    cond = 8'h01;
    tick();
    check_eq("t1_ne_a", {6'd0, ifa.pass}, 8'h00);
    check_eq("t1_sr_a", {4'd0, ifa.sr_flags}, 8'h04);

    // T2: full sweep on the combinational instance, both lanes
    for (int f = 0; f < 16; f++) begin
      flag_we = 1'b1; flag_in = 4'(f); cond_valid = 2'b00;
      tick();
      flag_we = 1'b0; cond_valid = 2'b11;
      for (int c = 0; c < 16; c++) begin
        cond = {4'(c), 4'(c)};
        #1;
        m = ref_cond(4'(c), 4'(f));
        check_eq($sformatf("t2_f%0h_c%0h", f, c), {6'd0, ifb.pass}, {6'd0, m, m});
      end
      check_eq("t2_pv_b", {6'd0, ifb.pass_valid}, 8'h03);
    end
    flag_we = 1'b1; flag_in = 4'b1001; cond_valid = 2'b01;
    tick();
    flag_we = 1'b0; cond = 8'h0C;
    #1;
    check_eq("t2_gt_nv", {6'd0, ifb.pass}, 8'h01);
    flag_we = 1'b1; flag_in = 4'b1000;
    tick();
    flag_we = 1'b0; cond = 8'h0D;
    #1;
    check_eq("t2_le_n", {6'd0, ifb.pass}, 8'h01);

    // T3: bypass of flag_in in the write cycle (SR currently N only)
    flag_we = 1'b1; flag_in = 4'b0010; cond = 8'h02; cond_valid = 2'b01;
    #1;
    check_eq("t3_nobyp_b", {6'd0, ifb.pass}, 8'h00);
    tick();
    check_eq("t3_byp_a", {6'd0, ifa.pass}, 8'h01);
    flag_we = 1'b0; cond_valid = 2'b00;

    // T4: IT block EQ, mask 0101, len 3, with Z set
    flag_we = 1'b1; flag_in = 4'b0100;
    tick();
    flag_we = 1'b0; it_load = 1'b1; it_cond = 4'h0; it_mask = 4'b0101; it_len = 3'd3;
    tick();
    it_load = 1'b0;
    check_eq("t4_busy_a", {7'd0, ifa.it_busy}, 8'h01);
    cond = 8'hEF; cond_valid = 2'b11;
    #1;
    check_eq("t4_i0_b", {6'd0, ifb.pass}, 8'h01);
    check_eq("t4_i0_pv_b", {6'd0, ifb.pass_valid}, 8'h01);
    tick();
    check_eq("t4_i0_a", {6'd0, ifa.pass}, 8'h01);
    check_eq("t4_i0_pv_a", {6'd0, ifa.pass_valid}, 8'h01);
    check_eq("t4_i1_b", {6'd0, ifb.pass}, 8'h00);
    tick();
    check_eq("t4_i1_a", {6'd0, ifa.pass}, 8'h00);
    check_eq("t4_i1_pv_a", {6'd0, ifa.pass_valid}, 8'h01);
    check_eq("t4_i2_b", {6'd0, ifb.pass}, 8'h01);
    tick();
    check_eq("t4_i2_a", {6'd0, ifa.pass}, 8'h01);
    check_eq("t4_done_a", {7'd0, ifa.it_busy}, 8'h00);
    check_eq("t4_after_b", {6'd0, ifb.pass}, 8'h02);
    cond_valid = 2'b00;
    tick();

    // T5: stall mid-block, then flush
    it_load = 1'b1; it_len = 3'd3;
    tick();
    it_load = 1'b0; cond = 8'h0F; cond_valid = 2'b01;
    tick();
    check_eq("t5_i0_a", {6'd0, ifa.pass}, 8'h01);
    stall = 1'b1;
    tick();
    check_eq("t5_hold1_a", {6'd0, ifa.pass}, 8'h01);
    check_eq("t5_hold1_b", {6'd0, ifb.pass}, 8'h00);
    tick();
    check_eq("t5_hold2_a", {6'd0, ifa.pass}, 8'h01);
    check_eq("t5_hold2_pv", {6'd0, ifa.pass_valid}, 8'h01);
    check_eq("t5_busy_a", {7'd0, ifa.it_busy}, 8'h01);
    stall = 1'b0;
    tick();
    check_eq("t5_i1_a", {6'd0, ifa.pass}, 8'h00);
    flush = 1'b1;
    tick();
    flush = 1'b0; cond_valid = 2'b00;
    check_eq("t5_flush_pv", {6'd0, ifa.pass_valid}, 8'h00);
    check_eq("t5_flush_busy", {7'd0, ifa.it_busy}, 8'h00);
    check_eq("t5_flush_sr", {4'd0, ifa.sr_flags}, 8'h04);

    // T6: reset mid-block, then load+flush together
    it_load = 1'b1;
    tick();
    it_load = 1'b0; cond_valid = 2'b01;
    tick();
    check_eq("t6_pre_a", {6'd0, ifa.pass}, 8'h01);
    rst = 1'b1;
    tick();
    check_eq("t6_rst_pass", {6'd0, ifa.pass}, 8'h00);
    check_eq("t6_rst_pv", {6'd0, ifa.pass_valid}, 8'h00);
    check_eq("t6_rst_busy", {7'd0, ifa.it_busy}, 8'h00);
    check_eq("t6_rst_sr", {4'd0, ifa.sr_flags}, 8'h00);
    rst = 1'b0; cond_valid = 2'b00;
    it_load = 1'b1; flush = 1'b1;
    tick();
    it_load = 1'b0; flush = 1'b0;
    check_eq("t6_ldfl_a", {7'd0, ifa.it_busy}, 8'h00);
    check_eq("t6_ldfl_b", {7'd0, ifb.it_busy}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
